// File: rtl/differentiator_pkg.sv
// Shared types and constants for the differentiator.
// It also holds the stand-ins for the synth and register-bank type packages.
// Optional feature macro: DIFF_SAT_COUNT_EN (saturation counter in differentiator).
package differentiator_pkg;

  // Synth signal path width and register-bank data width
  localparam int unsigned SYNTH_BITDEPTH  = 16;
  localparam int unsigned REG_DATA_W      = 32;

  // Differentiator defaults: 8-bit unsigned gain, unity gain = 1 << 7
  localparam int unsigned DIFF_GAIN_W     = 8;
  localparam int unsigned DIFF_GAIN_SHIFT = 7;
  localparam int unsigned DIFF_CNT_W      = 8;

  typedef logic [REG_DATA_W-1:0]            reg_data_t;
  typedef logic signed [SYNTH_BITDEPTH-1:0] synth_sig;

  // Full-precision product: (BITDEPTH+1)-bit difference times (GAIN_W+1)-bit signed gain
  typedef logic signed [SYNTH_BITDEPTH+DIFF_GAIN_W+1:0] diff_wide_t;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } diff_state_e;

endpackage

// File: rtl/differentiator_if.sv
// Control and sample bus for the differentiator.
// The voice chain drives it through the master modport.
// The differentiator sits on the slave modport.
interface differentiator_if
  import differentiator_pkg::*;
#(
  parameter int unsigned BITDEPTH = SYNTH_BITDEPTH,
  parameter int unsigned CNT_W    = DIFF_CNT_W
) ();

  logic                       enable;
  logic                       sample_en;
  reg_data_t                  freq_in;
  logic signed [BITDEPTH-1:0] sig_in;
  logic signed [BITDEPTH-1:0] sig_out;
  logic                       out_valid;
  logic                       sat_flag;
  logic [CNT_W-1:0]           sat_count;

  modport master (
    output enable,
    output sample_en,
    output freq_in,
    output sig_in,
    input  sig_out,
    input  out_valid,
    input  sat_flag,
    input  sat_count
  );

  modport slave (
    input  enable,
    input  sample_en,
    input  freq_in,
    input  sig_in,
    output sig_out,
    output out_valid,
    output sat_flag,
    output sat_count
  );

endinterface

// File: rtl/differentiator_sat_clip.sv
// Combinational signed saturator.
// It narrows an IN_W-bit signed value to OUT_W bits and flags when clipping occurred.
// IN_W must exceed OUT_W.
module differentiator_sat_clip
  import differentiator_pkg::*;
#(
  parameter int unsigned IN_W  = SYNTH_BITDEPTH + DIFF_GAIN_W + 2,
  parameter int unsigned OUT_W = SYNTH_BITDEPTH
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_clipped
);

  localparam int unsigned TOP_W = IN_W - OUT_W + 1;

  // Value fits iff every bit from the output sign bit upward equals the input sign
  logic [TOP_W-1:0] w_top;
  assign w_top = i_val[IN_W-1:OUT_W-1];

  // Pass through when representable, else pin to the rail on the input's side
  always_comb begin
    o_clipped = !((&w_top) || !(|w_top));
    o_val     = i_val[OUT_W-1:0];
    if (o_clipped) begin
      if (i_val[IN_W-1]) begin
        o_val = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        o_val = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/differentiator.sv
// Synth first-difference stage: y[n] = ((x[n] - x[n-1]) * gain) >>> GAIN_SHIFT.
// When disabled, sig_in passes straight through to sig_out.
// When enabled, a 3-stage pipeline with saturation computes the result.
// Optional feature macro: DIFF_SAT_COUNT_EN adds a saturating clip counter on sat_count.
// Without the macro, sat_count is tied to zero.
module differentiator
  import differentiator_pkg::*;
#(
  parameter int unsigned BITDEPTH   = SYNTH_BITDEPTH,
  parameter int unsigned GAIN_W     = DIFF_GAIN_W,
  parameter int unsigned GAIN_SHIFT = DIFF_GAIN_SHIFT,
  parameter int unsigned CNT_W      = DIFF_CNT_W
) (
  input logic             clk_in,
  input logic             reset_n,
  differentiator_if.slave bus
);

  localparam int unsigned D_W    = BITDEPTH + 1;
  localparam int unsigned WIDE_W = BITDEPTH + GAIN_W + 2;

  localparam logic [1:0] ST_OFF   = 2'(OFF);
  localparam logic [1:0] ST_PRIME = 2'(PRIME);
  localparam logic [1:0] ST_RUN   = 2'(RUN);

  logic                       w_enable;
  logic                       w_sample_en;
  logic signed [BITDEPTH-1:0] w_sig_in;
  logic [GAIN_W-1:0]          w_gain;
  logic                       w_unused_freq;

  assign w_enable      = bus.enable;
  assign w_sample_en   = bus.sample_en;
  assign w_sig_in      = bus.sig_in;
  assign w_gain        = bus.freq_in[GAIN_W-1:0];
  assign w_unused_freq = ^bus.freq_in[REG_DATA_W-1:GAIN_W];

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_prime;
  logic       w_launch;

  // Priming strobe only loads history; launch strobes start a difference
  assign w_prime  = w_enable && (r_state == ST_PRIME) && w_sample_en;
  assign w_launch = w_enable && (r_state == ST_RUN) && w_sample_en;

  // Next-state logic: dropping enable always returns to OFF
  always_comb begin
    w_state_next = r_state;
    if (!w_enable) begin
      w_state_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:   w_state_next = ST_PRIME;
        ST_PRIME: if (w_sample_en) w_state_next = ST_RUN;
        ST_RUN:   w_state_next = ST_RUN;
        default:  w_state_next = ST_OFF;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Previous-sample history, cleared whenever the block is disabled
  logic signed [BITDEPTH-1:0] r_x_prev;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_x_prev <= '0;
    end else if (!w_enable) begin
      r_x_prev <= '0;
    end else if (w_prime || w_launch) begin
      r_x_prev <= w_sig_in;
    end
  end

  // S1: full-width difference, plus the gain snapshot that travels with it
  logic signed [D_W-1:0] w_d;
  logic signed [D_W-1:0] r_d;
  logic [GAIN_W-1:0]     r_gain;
  logic                  r_v1;

  assign w_d = D_W'(w_sig_in) - D_W'(r_x_prev);

  // S1 register stage
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_d    <= '0;
      r_gain <= '0;
      r_v1   <= 1'b0;
    end else if (!w_enable) begin
      r_d    <= '0;
      r_gain <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= w_launch;
      if (w_launch) begin
        r_d    <= w_d;
        r_gain <= w_gain;
      end
    end
  end

  // S2: gain multiply, with the gain zero-extended so it stays non-negative
  logic signed [WIDE_W-1:0] w_p;
  logic signed [WIDE_W-1:0] r_p;
  logic                     r_v2;

  assign w_p = WIDE_W'(r_d) * WIDE_W'($signed({1'b0, r_gain}));

  // S2 register stage
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_p  <= '0;
      r_v2 <= 1'b0;
    end else if (!w_enable) begin
      r_p  <= '0;
      r_v2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p <= w_p;
      end
    end
  end

  // S3: arithmetic shift (floor), then clip back to the signal width
  logic signed [WIDE_W-1:0]   w_q;
  logic signed [BITDEPTH-1:0] w_clip;
  logic                       w_clipped;

  assign w_q = r_p >>> GAIN_SHIFT;

  differentiator_sat_clip #(
    .IN_W  (WIDE_W),
    .OUT_W (BITDEPTH)
  ) u_sat_clip (
    .i_val     (w_q),
    .o_val     (w_clip),
    .o_clipped (w_clipped)
  );

  logic signed [BITDEPTH-1:0] r_result;
  logic                       r_out_valid;
  logic                       r_sat_flag;

  // S3 register stage: result holds between pulses; flags are single-cycle
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_sat_flag  <= 1'b0;
    end else if (!w_enable) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_sat_flag  <= 1'b0;
    end else begin
      r_out_valid <= r_v2;
      r_sat_flag  <= r_v2 && w_clipped;
      if (r_v2) begin
        r_result <= w_clip;
      end
    end
  end

  // Bypass is combinational; pulses are masked the same cycle enable drops
  assign bus.sig_out   = w_enable ? r_result : w_sig_in;
  assign bus.out_valid = w_enable && r_out_valid;
  assign bus.sat_flag  = w_enable && r_sat_flag;

`ifdef DIFF_SAT_COUNT_EN
  logic [CNT_W-1:0] r_sat_count;

  // Clip counter: sticks at all-ones, survives disable, clears only on reset
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_count <= '0;
    end else if (w_enable && r_v2 && w_clipped && (r_sat_count != {CNT_W{1'b1}})) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign bus.sat_count = r_sat_count;
`else
  assign bus.sat_count = {CNT_W{1'b0}};
`endif

endmodule
